uart_tx_fifo_feeder: RTL and testbench

//  Byte buffer and frame sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_fifo_feeder.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO and frame sequencer in front of the UART transmitter: buffers bytes
// at clk rate and releases them one frame at a time using the newd/donetx handshake.
module uart_tx_fifo_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    output logic                     newd,
    output logic [7:0]               tx_data,
    input  logic                     donetx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    // The IDLE cycle that follows GAP also keeps newd low, so GAP itself
    // lasts GAP_CYCLES-1 cycles and newd is low for GAP_CYCLES cycles in total.
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   gap_cnt_q;
    logic            newd_q, ovf_q;
    logic [7:0]      tx_data_q;
    logic            sync1_q, sync2_q, sync_d_q;
    logic            done_rise, pop, push, drop;

    // NOTE: the synchroniser has no reset on purpose; it keeps tracking donetx
    // while rst is held, so a level that is already high at release is not a rise.
    always_ff @(posedge clk) begin
        sync1_q  <= donetx;
        sync2_q  <= sync1_q;
        sync_d_q <= sync2_q;
    end

    assign done_rise = sync2_q && !sync_d_q;

    assign s_ready = (level_q != FULL_LEVEL);
    // A pop on the same edge frees a slot, so a push while full still lands.
    assign push    = s_valid && (s_ready || pop);
    assign drop    = s_valid && !s_ready && !pop;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_rise) state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            newd_q    <= 1'b0;
            tx_data_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gap_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (pop) begin
                tx_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                newd_q    <= 1'b1;
            end else if (state_q == WAIT && done_rise) begin
                newd_q    <= 1'b0;
            end

            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);

            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + CW'(1) : '0;

            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

    assign newd    = newd_q;
    assign tx_data = tx_data_q;
    assign level   = level_q;
    assign busy    = (state_q != IDLE) || (level_q != '0);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: the bench plays the transmitter
// and keeps a queue of bytes that must come out, in order.
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          s_valid, s_ready, newd, donetx, busy, ovf, ovf_clr;
    logic [7:0]    s_data, tx_data;
    logic [LW-1:0] level;

    logic          g_s_valid, g_s_ready, g_newd, g_donetx, g_busy, g_ovf, g_ovf_clr;
    logic [7:0]    g_s_data, g_tx_data;
    logic [LW-1:0] g_level;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .newd(newd), .tx_data(tx_data), .donetx(donetx), .level(level),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(10)) dut_gap (
        .clk(clk), .rst(rst), .s_valid(g_s_valid), .s_data(g_s_data), .s_ready(g_s_ready),
        .newd(g_newd), .tx_data(g_tx_data), .donetx(g_donetx), .level(g_level),
        .busy(g_busy), .ovf(g_ovf), .ovf_clr(g_ovf_clr)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Transmitter model: wait for newd, hold the frame dly cycles, raise donetx,
    // then require newd to drop within 3 edges. Returns on the negedge newd is seen low.
    task automatic serve(input bit g, input logic [7:0] exp_b, input int dly, input string nm);
        int n;
        n = 0;
        while (!(g ? g_newd : newd) && n < 400) begin tick(); n++; end
        total++;
        if (!(g ? g_newd : newd)) begin
            bad++;
            $display("FAIL %s newd_start got=0 want=1 after %0d cycles", nm, n);
            return;
        end
        repeat (dly) tick();
        total++;
        if ((g ? g_tx_data : tx_data) !== exp_b) begin
            bad++;
            $display("FAIL %s tx_data got=%h want=%h", nm, g ? g_tx_data : tx_data, exp_b);
        end
        if (g) g_donetx = 1'b1; else donetx = 1'b1;
        n = 0;
        while ((g ? g_newd : newd) && n < 8) begin tick(); n++; end
        total++;
        if (n > 3) begin
            bad++;
            $display("FAIL %s newd_drop got=%0d edges want<=3", nm, n);
        end
        if (g) g_donetx = 1'b0; else donetx = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick();
        total++;
        if ({newd, tx_data, level, s_ready, busy, ovf} !== {1'b0, 8'h00, LW'(0), 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got newd=%b tx=%h lvl=%0d rdy=%b busy=%b ovf=%b want 0 00 0 1 0 0",
                     newd, tx_data, level, s_ready, busy, ovf);
        end
        total++;
        if ({g_newd, g_level, g_s_ready, g_busy} !== {1'b0, LW'(0), 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_gap_inst got newd=%b lvl=%0d rdy=%b busy=%b want 0 0 1 0",
                     g_newd, g_level, g_s_ready, g_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 8'hA5;
        tick();
        s_valid = 1'b0;
        total++;
        if (level !== LW'(1) || newd !== 1'b0) begin
            bad++;
            $display("FAIL single_edge_n got lvl=%0d newd=%b want lvl=1 newd=0", level, newd);
        end
        tick();
        total++;
        if (newd !== 1'b1 || tx_data !== 8'hA5 || level !== LW'(0) || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_edge_n1 got newd=%b tx=%h lvl=%0d busy=%b want 1 a5 0 1",
                     newd, tx_data, level, busy);
        end
        serve(1'b0, 8'hA5, 200, "single");
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_fill();
        int not_ready;
        not_ready = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (!s_ready) not_ready++;
            s_valid = 1'b1; s_data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        s_valid = 1'b0;
        total++;
        if (not_ready != 0) begin
            bad++;
            $display("FAIL fill_ready got=%0d stalls want=0", not_ready);
        end
        total++;
        if (level !== LW'(DEPTH) || s_ready !== 1'b0 || newd !== 1'b1 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL fill_full got lvl=%0d rdy=%b newd=%b tx=%h want 16 0 1 00",
                     level, s_ready, newd, tx_data);
        end
    endtask

    task automatic test_overflow();
        s_valid = 1'b1; s_data = 8'hFF;
        tick();
        s_valid = 1'b0;
        total++;
        if (level !== LW'(DEPTH) || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got lvl=%0d ovf=%b want 16 1", level, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", ovf);
        end
        s_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        s_valid = 1'b0; ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b1 || level !== LW'(DEPTH)) begin
            bad++;
            $display("FAIL ovf_clr_collide got ovf=%b lvl=%0d want 1 16", ovf, level);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_push_on_pop();
        serve(1'b0, exp_q.pop_front(), 5, "pop_first");
        total++;
        if (s_ready !== 1'b0 || level !== LW'(DEPTH)) begin
            bad++;
            $display("FAIL pop_full_idle got rdy=%b lvl=%0d want 0 16", s_ready, level);
        end
        s_valid = 1'b1; s_data = 8'hEE;
        exp_q.push_back(8'hEE);
        tick();
        s_valid = 1'b0;
        total++;
        if (level !== LW'(DEPTH) || newd !== 1'b1) begin
            bad++;
            $display("FAIL push_on_pop got lvl=%0d newd=%b want 16 1", level, newd);
        end
        while (exp_q.size() != 0) serve(1'b0, exp_q.pop_front(), 2 + $urandom_range(0, 6), "drain");
        tick();
        total++;
        if (level !== LW'(0) || busy !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL drain_end got lvl=%0d busy=%b ovf=%b want 0 0 0", level, busy, ovf);
        end
    endtask

    task automatic test_donetx_high();
        int drops;
        donetx = 1'b1;
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 8'h3C;
        tick();
        s_valid = 1'b0;
        tick();
        total++;
        if (newd !== 1'b1 || tx_data !== 8'h3C) begin
            bad++;
            $display("FAIL high_start got newd=%b tx=%h want 1 3c", newd, tx_data);
        end
        drops = 0;
        repeat (30) begin tick(); if (!newd) drops++; end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL high_premature got=%0d low cycles want=0", drops);
        end
        donetx = 1'b0;
        repeat (3) tick();
        serve(1'b0, 8'h3C, 2, "high_done");
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL high_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_gap();
        int zeros, k;
        g_s_valid = 1'b1; g_s_data = 8'hA1;
        tick();
        g_s_data = 8'hB2;
        tick();
        g_s_valid = 1'b0;
        serve(1'b1, 8'hA1, 4, "gap_first");
        zeros = 1;
        k = 0;
        while (!g_newd && k < 50) begin
            tick();
            k++;
            if (!g_newd) zeros++;
        end
        total++;
        if (zeros != 10 || g_newd !== 1'b1) begin
            bad++;
            $display("FAIL gap_len got=%0d idle cycles newd=%b want 10 1", zeros, g_newd);
        end
        total++;
        if (g_tx_data !== 8'hB2) begin
            bad++;
            $display("FAIL gap_second got=%h want=b2", g_tx_data);
        end
        g_s_valid = 1'b1; g_s_data = 8'hC3;
        tick();
        g_s_data = 8'hD4;
        tick();
        g_s_valid = 1'b0;
        total++;
        if (g_level !== LW'(2)) begin
            bad++;
            $display("FAIL gap_level got=%0d want=2", g_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (g_newd !== 1'b0 || g_level !== LW'(0) || g_busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_reset got newd=%b lvl=%0d busy=%b want 0 0 0", g_newd, g_level, g_busy);
        end
        tick();
    endtask

    task automatic test_random();
        localparam int N = 30;
        fork
            begin : producer
                for (int i = 0; i < N; i++) begin
                    int w;
                    logic [7:0] b;
                    repeat ($urandom_range(0, 3)) tick();
                    w = 0;
                    while (!s_ready && w < 2000) begin tick(); w++; end
                    b = 8'($urandom);
                    s_valid = 1'b1; s_data = b;
                    exp_q.push_back(b);
                    tick();
                    s_valid = 1'b0;
                end
            end
            begin : consumer
                for (int i = 0; i < N; i++) begin
                    int n;
                    n = 0;
                    while (!newd && n < 3000) begin tick(); n++; end
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rand_order got newd=%b with no byte queued", newd);
                    end else begin
                        serve(1'b0, exp_q.pop_front(), $urandom_range(2, 25), "rand");
                    end
                end
            end
        join
        tick();
        total++;
        if (level !== LW'(0) || busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_end got lvl=%0d busy=%b left=%0d want 0 0 0", level, busy, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = 8'h00; donetx = 1'b0; ovf_clr = 1'b0;
        g_s_valid = 1'b0; g_s_data = 8'h00; g_donetx = 1'b0; g_ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_push_on_pop();
        test_donetx_high();
        test_gap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
